// File: rtl/wait_mem.sv
// wait_mem: single-port simulation memory with configurable wait states,
// registered read data, a one-cycle ready pulse, byte-lane write enables and
// out-of-range error reporting. The read data drives the shared tri-state bus
// only during a read completion.
module wait_mem #(
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 2**ADDR_WIDTH,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = "simulation/rom.txt"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    rd,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [WORD_SIZE-1:0]    data,
  input  logic [WORD_SIZE/8-1:0]  be,
  output tri   [WORD_SIZE-1:0]    out,
  output logic                    ready,
  output logic                    err
);

  localparam int NB    = WORD_SIZE / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] WS_M1 = 8'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WORD_SIZE-1:0]    data_q;
  logic [NB-1:0]           be_q;
  logic                    rd_q;
  logic [WORD_SIZE-1:0]    rdata;

  logic [WORD_SIZE-1:0]    mem [DEPTH];

  logic                    accept;
  logic                    do_access;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [WORD_SIZE-1:0]    acc_data;
  logic [NB-1:0]           acc_be;
  logic                    acc_rd;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;

  // Zero-wait accesses use the live bus; waited accesses use the latched copy.
  always_comb begin
    accept    = en & (rd ^ wr);
    acc_addr  = (state == IDLE) ? addr : addr_q;
    acc_data  = (state == IDLE) ? data : data_q;
    acc_be    = (state == IDLE) ? be   : be_q;
    acc_rd    = (state == IDLE) ? rd   : rd_q;
    in_range  = (33'(acc_addr) < 33'(DEPTH));
    idx       = acc_addr[IDX_W-1:0];
    do_access = !rst && (((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                         ((state == WAIT) && (cnt == 8'd0)));
  end

  // Memory array: byte-lane write commit; never reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (do_access && in_range && !acc_rd) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) mem[idx][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end

  // Access controller: request acceptance, wait countdown and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      ready  <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      if (do_access) begin
        ready <= 1'b1;
        err   <= !in_range;
        if (acc_rd) rdata <= in_range ? mem[idx] : '0;
      end else begin
        ready <= 1'b0;
        err   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= addr;
            data_q <= data;
            be_q   <= be;
            rd_q   <= rd;
            if (WAIT_STATES == 0) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= WS_M1;
            end
          end
        end
        WAIT: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else             state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out = ((state == DONE) && rd_q) ? rdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_wait_mem.sv
// Bench for wait_mem: three instances (no wait states, 2 and 3 wait states),
// a transaction-level model with a per-cycle compare, and directed scenarios
// with literal expectations. The bus lines carry pullups, so an undriven
// bus reads as all ones.
module tb_wait_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en;
  logic        rd, wr;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [3:0]  be;
  wire  [31:0] out0, out1, out2;
  wire  [2:0]  ready, err;

  pullup (out0);
  pullup (out1);
  pullup (out2);

  always #5 clk = ~clk;

  wait_mem #(.WORD_SIZE(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .en(en[0]), .rd(rd), .wr(wr), .addr(addr),
    .data(data), .be(be), .out(out0), .ready(ready[0]), .err(err[0]));
  wait_mem #(.WORD_SIZE(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(2)) u1 (
    .clk(clk), .rst(rst), .en(en[1]), .rd(rd), .wr(wr), .addr(addr),
    .data(data), .be(be), .out(out1), .ready(ready[1]), .err(err[1]));
  wait_mem #(.WORD_SIZE(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(3)) u2 (
    .clk(clk), .rst(rst), .en(en[2]), .rd(rd), .wr(wr), .addr(addr),
    .data(data), .be(be), .out(out2), .ready(ready[2]), .err(err[2]));

  localparam logic [31:0] BUS_IDLE = 32'hFFFF_FFFF;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_on  = 0;

  int ws_k    [3] = '{0, 2, 3};
  int depth_k [3] = '{256, 16, 16};

  logic [31:0] mm     [3][256];
  bit          busy   [3];
  int          perf   [3];
  bit          t_rd   [3];
  int          t_addr [3];
  logic [31:0] t_data [3];
  logic [3:0]  t_be   [3];
  bit          e_rdy  [3];
  bit          e_err  [3];
  logic [31:0] e_val  [3];

  function automatic logic [31:0] outk(int k);
    case (k)
      0:       return out0;
      1:       return out1;
      default: return out2;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: an access accepted at edge c completes at edge c+ws,
  // is visible for one cycle, and the memory is free again two edges later.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      e_rdy[k] = 0;
      e_err[k] = 0;
      e_val[k] = BUS_IDLE;
      if (rst) begin
        busy[k] = 0;
      end else begin
        if (!busy[k] && en[k] && (rd ^ wr)) begin
          busy[k]   = 1;
          perf[k]   = cyc + ws_k[k];
          t_rd[k]   = rd;
          t_addr[k] = int'(addr);
          t_data[k] = data;
          t_be[k]   = be;
        end
        if (busy[k] && cyc == perf[k]) begin
          e_rdy[k] = 1;
          e_err[k] = (t_addr[k] >= depth_k[k]);
          if (!e_err[k] && !t_rd[k])
            for (int b = 0; b < 4; b++)
              if (t_be[k][b]) mm[k][t_addr[k]][8*b +: 8] = t_data[k][8*b +: 8];
          if (t_rd[k]) e_val[k] = e_err[k] ? 32'h0 : mm[k][t_addr[k]];
        end else if (busy[k] && cyc == perf[k] + 1) begin
          busy[k] = 0;
        end
      end
    end
  end

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("ready%0d", k), {31'b0, ready[k]}, {31'b0, e_rdy[k]});
        check($sformatf("err%0d", k),   {31'b0, err[k]},   {31'b0, e_err[k]});
        check($sformatf("out%0d", k),   outk(k),           e_val[k]);
      end
    end
  end

  task automatic access(input int k, input bit r, input bit w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rv, output logic e, output int lat);
    bit seen;
    @(negedge clk);
    en = '0; en[k] = 1'b1; rd = r; wr = w; addr = a; data = d; be = b;
    lat = 0; rv = BUS_IDLE; e = 1'b0; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (ready[k]) begin
        seen = 1;
        rv   = outk(k);
        e    = err[k];
      end
    end
    en = '0; rd = 1'b0; wr = 1'b0;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL timeout%0d: got no ready expected ready within 300 cycles", k);
    end
  endtask

  logic [31:0] rv;
  logic        e;
  int          lat;
  int          c0;
  int          rdy_cyc [$];

  initial begin
    rst = 1'b1; en = '0; rd = 1'b0; wr = 1'b0; addr = '0; data = '0; be = '0;
    @(negedge clk);
    chk_on = 1;
    check("reset_ready", {29'b0, ready}, 32'h0);
    check("reset_out0", out0, BUS_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Zero wait states: write then read back, one-cycle latency each.
    access(0, 0, 1, 8'h10, 32'h1122_3344, 4'hF, rv, e, lat);
    check("zw_wr_lat", lat, 1);
    check("zw_wr_out", rv, BUS_IDLE);
    access(0, 1, 0, 8'h10, 32'h0, 4'h0, rv, e, lat);
    check("zw_rd_lat", lat, 1);
    check("zw_rd_val", rv, 32'h1122_3344);

    // Byte lanes: only lanes 0 and 2 are cleared.
    access(0, 0, 1, 8'h02, 32'hAABB_CCDD, 4'hF, rv, e, lat);
    access(0, 0, 1, 8'h02, 32'h0000_0000, 4'b0101, rv, e, lat);
    access(0, 1, 0, 8'h02, 32'h0, 4'h0, rv, e, lat);
    check("be_val", rv, 32'hAA00_CC00);
    access(0, 0, 1, 8'h02, 32'h5555_5555, 4'h0, rv, e, lat);
    access(0, 1, 0, 8'h02, 32'h0, 4'hF, rv, e, lat);
    check("be0_noop", rv, 32'hAA00_CC00);

    // Illegal request: rd and wr together must never complete.
    access(0, 0, 1, 8'h00, 32'h0BAD_C0DE, 4'hF, rv, e, lat);
    @(negedge clk);
    en = 3'b001; rd = 1'b1; wr = 1'b1; addr = 8'h00; data = 32'h0; be = 4'hF;
    repeat (5) @(negedge clk);
    en = '0; rd = 1'b0; wr = 1'b0;
    access(0, 1, 0, 8'h00, 32'h0, 4'h0, rv, e, lat);
    check("illegal_mem", rv, 32'h0BAD_C0DE);
    check("illegal_err", {31'b0, e}, 32'h0);

    // Out of range on a 16-word instance; addr 20 must not alias onto word 4.
    access(1, 0, 1, 8'd4, 32'hCAFE_F00D, 4'hF, rv, e, lat);
    check("ws2_lat", lat, 3);
    access(1, 0, 1, 8'd20, 32'h1, 4'hF, rv, e, lat);
    check("oor_wr_err", {31'b0, e}, 32'h1);
    access(1, 1, 0, 8'd20, 32'h0, 4'h0, rv, e, lat);
    check("oor_rd_err", {31'b0, e}, 32'h1);
    check("oor_rd_val", rv, 32'h0);
    access(1, 1, 0, 8'd4, 32'h0, 4'h0, rv, e, lat);
    check("oor_mem4", rv, 32'hCAFE_F00D);
    check("inr_err", {31'b0, e}, 32'h0);

    // Back-to-back reads with the request held: completions at c+2 and c+6.
    @(negedge clk);
    en = 3'b010; rd = 1'b1; wr = 1'b0; addr = 8'd4;
    c0 = cyc + 1;
    repeat (10) begin
      @(negedge clk);
      if (ready[1]) rdy_cyc.push_back(cyc - c0);
    end
    en = '0; rd = 1'b0;
    check("b2b_count", rdy_cyc.size(), 2);
    if (rdy_cyc.size() == 2) begin
      check("b2b_first", rdy_cyc[0], 2);
      check("b2b_second", rdy_cyc[1], 6);
    end
    repeat (6) @(negedge clk);

    // Reset in the middle of a waited write: nothing commits, no ready.
    access(2, 0, 1, 8'd5, 32'h1234_5678, 4'hF, rv, e, lat);
    check("ws3_lat", lat, 4);
    @(negedge clk);
    en = 3'b100; rd = 1'b0; wr = 1'b1; addr = 8'd5; data = 32'hDEAD_BEEF; be = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1; en = '0; wr = 1'b0;
    @(negedge clk);
    check("rst_ready", {29'b0, ready}, 32'h0);
    check("rst_out2", out2, BUS_IDLE);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    access(2, 1, 0, 8'd5, 32'h0, 4'h0, rv, e, lat);
    check("rst_mem5", rv, 32'h1234_5678);
    check("rst_lat", lat, 4);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
